// File: rtl/edp_mul_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : edp_mul_seq
// Purpose  : Multiply-step sequencer for the EBOX data path. Drives the EDP
//            CRAM/CTL control lines cycle by cycle for a shift-and-add
//            multiply (BR x MQ -> AR:MQ), with an optional signed FIXUP step.
// Revision : 1.0 - initial release
// ============================================================================
module edp_mul_seq #(
    parameter int STEPS = 36
) (
    input  logic       eboxClk,
    input  logic       resetN,
    input  logic       start,
    input  logic       signedOp,
    input  logic       mq35,
    input  logic       mq0Init,
    output logic       busy,
    output logic       done,
    output logic [5:0] CRAM_AD,
    output logic [2:0] CRAM_ADA,
    output logic       CRAM_ADA_EN,
    output logic [1:0] CRAM_ADB,
    output logic [2:0] CTL_ARL_SEL,
    output logic [2:0] CTL_ARR_SEL,
    output logic       CTL_AR00to08load,
    output logic       CTL_AR09to17load,
    output logic       CTL_ARRload,
    output logic       CTL_AR00to11clr,
    output logic       CTL_AR12to17clr,
    output logic       CTL_ARRclr,
    output logic [1:0] CTL_MQ_SEL,
    output logic       CTL_MQM_EN,
    output logic       CTL_ADcarry36,
    output logic       CTL_ADlong
);

    // AD function codes and mux selects used by the multiply
    localparam logic [5:0] c_AD_A       = 6'b011111;
    localparam logic [5:0] c_AD_APLUSB  = 6'b000110;
    localparam logic [5:0] c_AD_AMINUSB = 6'b011001;
    localparam logic [2:0] c_ADA_AR     = 3'b000;
    localparam logic [1:0] c_ADB_BR     = 2'b10;
    localparam logic [2:0] c_AR_RECIRC  = 3'd0;
    localparam logic [2:0] c_AR_ADHALF  = 3'd5;
    localparam logic [1:0] c_MQ_HOLD    = 2'd0;
    localparam logic [1:0] c_MQ_SHIFT   = 2'd1;
    localparam logic [5:0] c_CNT_INIT   = 6'(STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLRAR = 3'd1,
        S_STEP  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_step_cnt;
    logic       r_sgn;

    // State register
    always_ff @(posedge eboxClk or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Step counter and sign latch: loaded on accepted start, counter saturates at zero
    always_ff @(posedge eboxClk or negedge resetN) begin
        if (!resetN) begin
            r_step_cnt <= 6'd0;
            r_sgn      <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_step_cnt <= c_CNT_INIT;
            r_sgn      <= signedOp & mq0Init;
        end else if (r_state == S_STEP && r_step_cnt != 6'd0) begin
            r_step_cnt <= r_step_cnt - 6'd1;
        end
    end

    // Next-state and control outputs; defaults are the benign recirculate values
    always_comb begin
        w_state_next     = r_state;
        busy             = (r_state != S_IDLE);
        done             = 1'b0;
        CRAM_AD          = c_AD_A;
        CRAM_ADA         = c_ADA_AR;
        CRAM_ADA_EN      = 1'b0;
        CRAM_ADB         = 2'b00;
        CTL_ARL_SEL      = c_AR_RECIRC;
        CTL_ARR_SEL      = c_AR_RECIRC;
        CTL_AR00to08load = 1'b0;
        CTL_AR09to17load = 1'b0;
        CTL_ARRload      = 1'b0;
        CTL_AR00to11clr  = 1'b0;
        CTL_AR12to17clr  = 1'b0;
        CTL_ARRclr       = 1'b0;
        CTL_MQ_SEL       = c_MQ_HOLD;
        CTL_MQM_EN       = 1'b0;
        CTL_ADcarry36    = 1'b0;
        CTL_ADlong       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_CLRAR;
            end
            S_CLRAR: begin
                CTL_AR00to11clr = 1'b1;
                CTL_AR12to17clr = 1'b1;
                CTL_ARRclr      = 1'b1;
                w_state_next    = S_STEP;
            end
            S_STEP: begin
                // mq35 is the post-shift multiplier LSB presented by the EDP this cycle
                CRAM_AD          = mq35 ? c_AD_APLUSB : c_AD_A;
                CRAM_ADB         = c_ADB_BR;
                CTL_ARL_SEL      = c_AR_ADHALF;
                CTL_ARR_SEL      = c_AR_ADHALF;
                CTL_AR00to08load = 1'b1;
                CTL_AR09to17load = 1'b1;
                CTL_ARRload      = 1'b1;
                CTL_MQ_SEL       = c_MQ_SHIFT;
                CTL_MQM_EN       = 1'b1;
                CTL_ADlong       = 1'b1;
                if (r_step_cnt == 6'd0) w_state_next = r_sgn ? S_FIXUP : S_DONE;
            end
            S_FIXUP: begin
                // Negative multiplier: subtract the multiplicand from the high word
                CRAM_AD          = c_AD_AMINUSB;
                CRAM_ADB         = c_ADB_BR;
                CTL_ADcarry36    = 1'b1;
                CTL_ARL_SEL      = c_AR_ADHALF;
                CTL_ARR_SEL      = c_AR_ADHALF;
                CTL_AR00to08load = 1'b1;
                CTL_AR09to17load = 1'b1;
                CTL_ARRload      = 1'b1;
                CTL_MQ_SEL       = c_MQ_SHIFT;
                CTL_MQM_EN       = 1'b1;
                w_state_next     = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/edp_mul_seq.md
# edp_mul_seq

Multiply-step sequencer for the EBOX data path (EDP). On a start request it drives the EDP's CRAM-field and CTL control inputs cycle by cycle to perform a shift-and-add multiply:
- operands: multiplicand in BR, multiplier in MQ;
- result: high word in AR, low word in MQ.

It sits between the CRAM/CTL decode and the EDP, and owns those control lines only while busy. When idle, it drives benign recirculate values.

## Interface
Parameters:
- STEPS, 36, number of add/shift steps (operand width); legal range 2..63.

Ports (clock and reset first):
- eboxClk  input  1  EBOX clock; all state changes on posedge.
- resetN  input  1  reset, asynchronous, active-low.
- start  input  1  request a multiply; sampled only in IDLE.
- signedOp  input  1  sampled with start; 1 = two's-complement multiply (adds FIXUP).
- mq35  input  1  EDP_MQ[35], current multiplier LSB.
- mq0Init  input  1  EDP_MQ[0], sampled with start (multiplier sign).
- busy  output  1  high from the cycle after start is accepted through the DONE state.
- done  output  1  one-cycle pulse in DONE.
- CRAM_AD  output  6  AD function.
- CRAM_ADA  output  3  AD A-mux select.
- CRAM_ADA_EN  output  1  0 = A-input enabled.
- CRAM_ADB  output  2  AD B-mux select.
- CTL_ARL_SEL, CTL_ARR_SEL  output  3 each  AR half source selects.
- CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload  output  1 each  AR load enables.
- CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr  output  1 each  AR clears.
- CTL_MQ_SEL  output  2  MQ source select.
- CTL_MQM_EN  output  1  MQ mux enable.
- CTL_ADcarry36  output  1  carry into AD bit 35.
- CTL_ADlong  output  1  long AD/ADX operation.

## Operation
Control encodings (fixed for this block):
- CRAM_AD: A = 6'b011111, A+B = 6'b000110, A−B = 6'b011001.
- CRAM_ADA = 3'b000 (AR). CRAM_ADB = 2'b10 (BR).
- AR selects: 3'd0 = recirculate, 3'd5 = AD*.5.
- MQ selects: 2'd0 = hold, 2'd1 = MQ*.5 with AD[35] into MQ[0].

State machine:
- IDLE: all loads/clears/enables 0; CRAM_AD = A; selects 0; CTL_ADcarry36 = 0.
  - start=1 → CLRAR; latch signedOp and mq0Init into sgn = signedOp & mq0Init; stepCnt ← STEPS−1.
- CLRAR: assert all three AR clears → STEP.
- STEP: CRAM_AD = mq35 ? A+B : A; CRAM_ADA = 000; CRAM_ADB = 10; ADA_EN = 0.
  - AR: ARL_SEL = ARR_SEL = 5; all three AR loads = 1.
  - MQ: MQ_SEL = 1; MQM_EN = 1; ADlong = 1.
  - stepCnt == 0 → (sgn ? FIXUP : DONE); otherwise decrement stepCnt.
- FIXUP: CRAM_AD = A−B; CTL_ADcarry36 = 1; ARL/ARR_SEL = 5 with all AR loads; MQ_SEL = 1; MQM_EN = 1 → DONE.
- DONE: done = 1; IDLE control values → IDLE.

Rules:
- start is ignored outside IDLE; there is no queueing.
- start held high across DONE→IDLE launches a new multiply from IDLE on the next sample.
- stepCnt is 6 bits and never wraps: decrement only when nonzero.
- mq35 is used combinationally in STEP. The EDP must present the post-shift MQ each cycle.

## Timing
- Reset (async, resetN=0): state = IDLE, busy = 0, done = 0, all outputs at IDLE values, stepCnt = 0, sgn = 0. Takes effect immediately, including mid-multiply; the EDP result is then undefined.
- Latency: start sampled at edge 0.
  - CLRAR in cycle 1.
  - STEP in cycles 2..STEPS+1.
  - FIXUP (signed negative multiplier only) in cycle STEPS+2.
  - done in cycle STEPS+2 (unsigned) or STEPS+3 (FIXUP).
- busy high in cycles 1 through the done cycle inclusive; low in IDLE.
- Back-to-back: start high on the done cycle is not accepted. It is accepted in the following IDLE cycle.

## Test plan
- Reset: resetN=0 while start=1 → busy=0, done=0, CRAM_AD=6'b011111, all loads 0; release → IDLE until start.
- Unsigned, STEPS=36, mq35 held 1: start at edge 0 → CLRAR clears at cycle 1; 36 cycles of CRAM_AD=000110 with AR loads and MQ_SEL=1; done at cycle 38; busy high for cycles 1..38.
- mq35 pattern 1,0,1,0…: CRAM_AD alternates 000110 / 011111 on consecutive STEP cycles. With a behavioural EDP model, BR=3 and MQ=5 → AR=0, MQ=15 at done.
- Signed, mq0Init=1, signedOp=1: FIXUP appears at cycle 38 (CRAM_AD=011001, ADcarry36=1) and done at cycle 39. Behavioural model with BR=2, MQ=−3 → AR=36'hFFFFFFFFF, MQ=36'hFFFFFFFFA.
- start pulsed during STEP → ignored; completion timing unchanged; start held high through done → second run begins one cycle after the done pulse.
- resetN asserted at cycle 10 mid-STEP → outputs return to IDLE values asynchronously; after release a new start completes normally.
